tiny_tensor_cpu: RTL and testbench
==================================

Name: tiny_tensor_cpu

Overview:
- Small 8-bit CPU with an attached 3x3 tensor (matrix-multiply) core.
- Executes one 16-bit instruction per clock, supplied on a flat instruction port; there is no fetch unit.
- Holds 8 scalar registers (R0-R7) and 18 tensor registers: matrix A = T0-T8, matrix B = T9-T17, row-major.
- Exposes one registered output byte for results and a done flag for the tensor core.

Parameters:
- DATA_WIDTH, 8, width of every register, tensor element and cpu_output (two's-complement signed).

Ports:
- clock_in  input  1  system clock; all state updates on the rising edge.
- reset_n_in  input  1  asynchronous active-low reset.
- current_instruction  input  16  instruction sampled on each rising edge.
- cpu_output  output  DATA_WIDTH  registered result of READ instructions.
- tensor_core_done  output  1  high when the last matrix multiply has completed.

Behaviour:
- Encoding: opcode = [15:12]. Scalar fields: rd = [11:9], rs1 = [8:6], rs2 = [5:3]. Tensor fields: td/ts = [11:7] (valid 0-17). Indices 18-31 suppress any write and read as 0.
- Reset (reset_n_in low, asynchronous): all R and T registers = 0, result buffer = 0, cpu_output = 0, tensor_core_done = 0, tensor FSM = IDLE.
- Opcodes (all writes take effect at the rising edge; the new value is readable by the next instruction):
  - 0 ADD: rd = rs1 + rs2, wraps mod 256.
  - 1 SUB: rd = rs1 - rs2, wraps mod 256.
  - 2 MUL: rd = low 8 bits of rs1 * rs2.
  - 3 EQL: rd = 1 if rs1 == rs2, else 0.
  - 4 GRT: rd = 1 if rs1 > rs2 (signed compare), else 0.
  - 5 TENSOR_CORE_OPERATE: if IDLE, start C = A x B, clear done, enter BUSY. If already BUSY, ignored.
  - 6 TENSOR_CORE_LOAD: bulk-copy result buffer C into A (bit[11] = 0) or B (bit[11] = 1), all 9 elements in one cycle. Ignored while BUSY.
  - 7 CPU_TO_TENSOR_CORE: T[td] = R[[6:4]].
  - 8 TENSOR_CORE_TO_CPU: R[rd] = T[[8:4]].
  - 9 NOP: no state change.
  - A ADD_IMM: rd = rd + signed imm [7:0], wraps.
  - B MOVE_CPU: R[rd] = R[rs1].
  - C MOVE_TENSOR_CORE: T[td] = T[[6:2]].
  - D RESET: same effect as the hardware reset, applied synchronously.
  - E READ_CPU: cpu_output = R[[11:9]].
  - F READ_TENSOR_CORE: cpu_output = T[td].
- cpu_output updates only on READ instructions or reset; otherwise it holds its value.
- Tensor FSM has states IDLE and BUSY. BUSY computes one element per cycle, index k = 0..8, with i = k/3 and j = k%3:
  - C[k] = sum over n of A[i][n] * B[n][j], accumulated at full width (at least 18 bits), then truncated to 8 bits.
- Operands are read live each cycle. A write to A or B during BUSY affects only elements not yet computed.
- Timing: on the cycle that writes C[8], the FSM returns to IDLE and tensor_core_done is set (visible 9 cycles after the OPERATE edge). Done stays high until the next OPERATE or reset.
- Scalar instructions execute normally while the tensor core is BUSY.
- RESET or reset_n_in asserted mid-computation aborts it: C is cleared and done = 0.

Optional Feature:
- Macro: TENSOR_SATURATE_EN.
  - Defined: each C element is clamped to [-128, 127] instead of truncated.
  - Undefined: C elements wrap (low 8 bits).
  - Scalar ALU ops always wrap, with or without the macro.

Test Plan:
- Scalar arithmetic: ADD_IMM R1 += 5, ADD_IMM R2 += -3, ADD R3 = R1 + R2, READ_CPU R3 -> cpu_output = 2. MUL R4 = R1 * R1 -> READ gives 25. GRT R5 = R2 > R1 -> READ gives 0.
- Wrap: ADD_IMM R1 = 127, then ADD_IMM R1 += 1, READ_CPU R1 -> cpu_output = -128.
- Tensor path:
  - Load A = identity and B = 1..9 via ADD_IMM + CPU_TO_TENSOR_CORE.
  - OPERATE, wait until tensor_core_done = 1 (exactly 9 cycles).
  - TENSOR_CORE_LOAD into A, then READ_TENSOR_CORE T0..T8 -> 1..9.
- Overflow: A and B all 20, OPERATE -> each element = 1200 -> 0xB0 (-80) without the macro, 127 with TENSOR_SATURATE_EN.
- Reset mid-operation: OPERATE, then RESET after 4 cycles -> done stays 0, all T read 0, cpu_output = 0. Repeat using reset_n_in low asynchronously -> same result.
- Invalid index: CPU_TO_TENSOR_CORE with td = 20 -> no tensor register changes. READ_TENSOR_CORE ts = 25 -> cpu_output = 0.

Source files
------------

// File: rtl/tiny_tensor_cpu.sv
// tiny_tensor_cpu: 8-bit scalar CPU with an attached 3x3 matrix-multiply core.
// Define TENSOR_SATURATE_EN to clamp tensor results instead of wrapping them.

module tiny_tensor_cpu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic [15:0]           current_instruction,
    output logic [DATA_WIDTH-1:0] cpu_output,
    output logic                  tensor_core_done
);

    typedef enum logic [3:0] {
        OP_ADD     = 4'h0, OP_SUB      = 4'h1,
        OP_MUL     = 4'h2, OP_EQL      = 4'h3,
        OP_GRT     = 4'h4, OP_OPERATE  = 4'h5,
        OP_LOAD    = 4'h6, OP_C2T      = 4'h7,
        OP_T2C     = 4'h8, OP_NOP      = 4'h9,
        OP_ADD_IMM = 4'hA, OP_MOVE_CPU = 4'hB,
        OP_MOVE_T  = 4'hC, OP_RESET    = 4'hD,
        OP_READ_C  = 4'hE, OP_READ_T   = 4'hF
    } op_t;

    typedef enum logic {IDLE, BUSY} state_t;

`ifdef TENSOR_SATURATE_EN
    localparam int ACC_W = 2 * DATA_WIDTH + 2;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        ACC_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`else
    // Wrapping keeps only the low bits, so a narrow sum is exact mod 2^N
    localparam int ACC_W = DATA_WIDTH;
`endif

    logic signed [DATA_WIDTH-1:0] r [8];
    logic signed [DATA_WIDTH-1:0] t [18];
    logic signed [DATA_WIDTH-1:0] c [9];
    state_t                       state;
    logic [3:0]                   k;

    op_t                          op;
    logic [2:0]                   rd, rs1, rs2, rsc;
    logic [4:0]                   td, tsm, tsc;
    logic signed [DATA_WIDTH-1:0] imm;

    assign op  = op_t'(current_instruction[15:12]);
    assign rd  = current_instruction[11:9];
    assign rs1 = current_instruction[8:6];
    assign rs2 = current_instruction[5:3];
    assign rsc = current_instruction[6:4];
    assign td  = current_instruction[11:7];
    assign tsm = current_instruction[6:2];
    assign tsc = current_instruction[8:4];
    assign imm = DATA_WIDTH'(signed'(current_instruction[7:0]));

    logic signed [DATA_WIDTH-1:0] ts_val, tm_val, tc_val;
    logic signed [DATA_WIDTH-1:0] alu_res, c_elem;
    logic                         wr_r;

    always_comb begin
        ts_val = (td  < 5'd18) ? t[td]  : '0;
        tm_val = (tsm < 5'd18) ? t[tsm] : '0;
        tc_val = (tsc < 5'd18) ? t[tsc] : '0;
    end

    always_comb begin
        alu_res = '0;
        wr_r    = 1'b1;
        case (op)
            OP_ADD:      alu_res = r[rs1] + r[rs2];
            OP_SUB:      alu_res = r[rs1] - r[rs2];
            OP_MUL:      alu_res = r[rs1] * r[rs2];
            OP_EQL:      alu_res = DATA_WIDTH'(r[rs1] == r[rs2]);
            OP_GRT:      alu_res = DATA_WIDTH'(r[rs1] > r[rs2]);
            OP_ADD_IMM:  alu_res = r[rd] + imm;
            OP_MOVE_CPU: alu_res = r[rs1];
            OP_T2C:      alu_res = tc_val;
            default:     wr_r    = 1'b0;
        endcase
    end

    logic [3:0]              row, col;
    logic [4:0]              ai, bi;
    logic signed [ACC_W-1:0] acc;

    // One dot product per cycle; operands are read live from A and B
    always_comb begin
        row = k / 4'd3;
        col = k % 4'd3;
        acc = '0;
        ai  = '0;
        bi  = '0;
        for (int n = 0; n < 3; n++) begin
            ai  = 5'(3 * row + n);
            bi  = 5'(9 + 3 * n + col);
            acc = acc + ACC_W'(t[ai]) * ACC_W'(t[bi]);
        end
`ifdef TENSOR_SATURATE_EN
        if (acc > SAT_MAX)
            c_elem = SAT_MAX[DATA_WIDTH-1:0];
        else if (acc < SAT_MIN)
            c_elem = SAT_MIN[DATA_WIDTH-1:0];
        else
            c_elem = acc[DATA_WIDTH-1:0];
`else
        c_elem = acc;
`endif
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < 8; i++)  r[i] <= '0;
            for (int i = 0; i < 18; i++) t[i] <= '0;
            for (int i = 0; i < 9; i++)  c[i] <= '0;
            state            <= IDLE;
            k                <= '0;
            tensor_core_done <= 1'b0;
            cpu_output       <= '0;
        end else if (op == OP_RESET) begin
            for (int i = 0; i < 8; i++)  r[i] <= '0;
            for (int i = 0; i < 18; i++) t[i] <= '0;
            for (int i = 0; i < 9; i++)  c[i] <= '0;
            state            <= IDLE;
            k                <= '0;
            tensor_core_done <= 1'b0;
            cpu_output       <= '0;
        end else begin
            if (state == BUSY) begin
                c[k] <= c_elem;
                if (k == 4'd8) begin
                    state            <= IDLE;
                    k                <= '0;
                    tensor_core_done <= 1'b1;
                end else begin
                    k <= k + 4'd1;
                end
            end
            if (wr_r)
                r[rd] <= alu_res;
            case (op)
                OP_OPERATE:
                    if (state == IDLE) begin
                        state            <= BUSY;
                        k                <= '0;
                        tensor_core_done <= 1'b0;
                    end
                OP_LOAD:
                    if (state == IDLE)
                        for (int i = 0; i < 9; i++)
                            if (current_instruction[11])
                                t[9 + i] <= c[i];
                            else
                                t[i] <= c[i];
                OP_C2T:
                    if (td < 5'd18) t[td] <= r[rsc];
                OP_MOVE_T:
                    if (td < 5'd18) t[td] <= tm_val;
                OP_READ_C: cpu_output <= r[rd];
                OP_READ_T: cpu_output <= ts_val;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tiny_tensor_cpu.sv
// Scoreboard bench for tiny_tensor_cpu: READ results are queued at issue time
// and compared by an independent monitor when cpu_output updates.

module tb_tiny_tensor_cpu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = 16'h9000;
    logic [7:0]  cpu_output;
    logic        done;

    always #5 clk = ~clk;

    tiny_tensor_cpu #(.DATA_WIDTH(8)) dut (
        .clock_in           (clk),
        .reset_n_in         (rst_n),
        .current_instruction(instr),
        .cpu_output         (cpu_output),
        .tensor_core_done   (done)
    );

    localparam logic [15:0] NOP = 16'h9000;
    localparam logic [15:0] OPR = 16'h5000;
    localparam logic [15:0] RST = 16'hD000;

`ifdef TENSOR_SATURATE_EN
    localparam logic [7:0] OVF = 8'h7F;
`else
    localparam logic [7:0] OVF = 8'hB0;
`endif

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    logic out_valid = 1'b0;
    int   lat;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk)
        out_valid <= (instr[15:12] == 4'hE) || (instr[15:12] == 4'hF);

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got %0d expected none",
                         cpu_output);
            end else begin
                e = sbq.pop_front();
                chk(e.name, {24'b0, cpu_output}, {24'b0, e.val});
            end
        end
    end

    function automatic logic [15:0] alu(input logic [3:0] op, input int d,
                                        input int s1, input int s2);
        return {op, 3'(d), 3'(s1), 3'(s2), 3'b000};
    endfunction
    function automatic logic [15:0] addi(input int d, input logic [7:0] v);
        return {4'hA, 3'(d), 1'b0, v};
    endfunction
    function automatic logic [15:0] c2t(input int td, input int rs);
        return {4'h7, 5'(td), 3'(rs), 4'b0000};
    endfunction
    function automatic logic [15:0] t2c(input int d, input int ts);
        return {4'h8, 3'(d), 5'(ts), 4'b0000};
    endfunction
    function automatic logic [15:0] mvt(input int td, input int ts);
        return {4'hC, 5'(td), 5'(ts), 2'b00};
    endfunction
    function automatic logic [15:0] rdc(input int r);
        return {4'hE, 3'(r), 9'b0};
    endfunction
    function automatic logic [15:0] rdt(input int td);
        return {4'hF, 5'(td), 7'b0};
    endfunction
    function automatic logic [15:0] ld(input logic b);
        return {4'h6, b, 11'b0};
    endfunction

    task automatic issue(input logic [15:0] i);
        @(negedge clk);
        instr = i;
    endtask

    task automatic rd_exp(input logic [15:0] i, input string name,
                          input logic [7:0] v);
        issue(i);
        sbq.push_back('{name, v});
    endtask

    task automatic set_t(input int idx, input logic [7:0] v);
        issue(alu(4'h1, 6, 6, 6));
        issue(addi(6, v));
        issue(c2t(idx, 6));
    endtask

    task automatic run_mul(output int l);
        issue(OPR);
        issue(NOP);
        chk("done_cleared", {31'b0, done}, 0);
        l = 0;
        while (!done && l < 20) begin
            issue(NOP);
            l++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_out", {24'b0, cpu_output}, 0);
        chk("reset_done", {31'b0, done}, 0);
        rst_n = 1'b1;
        rd_exp(rdc(0), "r0_reset", 8'd0);

        issue(addi(1, 8'd5));
        issue(addi(2, 8'hFD));
        issue(alu(4'h0, 3, 1, 2));
        rd_exp(rdc(3), "add", 8'd2);
        issue(alu(4'h2, 4, 1, 1));
        rd_exp(rdc(4), "mul", 8'd25);
        issue(alu(4'h4, 5, 2, 1));
        rd_exp(rdc(5), "grt_false", 8'd0);
        issue(alu(4'h4, 5, 1, 2));
        rd_exp(rdc(5), "grt_signed", 8'd1);
        issue(alu(4'h1, 6, 2, 1));
        rd_exp(rdc(6), "sub", 8'hF8);
        issue(alu(4'h3, 7, 1, 1));
        rd_exp(rdc(7), "eql_true", 8'd1);
        issue(alu(4'h3, 7, 1, 2));
        rd_exp(rdc(7), "eql_false", 8'd0);
        issue(alu(4'hB, 0, 4, 0));
        rd_exp(rdc(0), "move_cpu", 8'd25);

        issue(addi(1, 8'd122));
        issue(addi(1, 8'd1));
        rd_exp(rdc(1), "wrap", 8'h80);

        for (int i = 0; i < 18; i++)
            if (i < 9)
                set_t(i, (i == 0 || i == 4 || i == 8) ? 8'd1 : 8'd0);
            else
                set_t(i, 8'(i - 8));
        run_mul(lat);
        chk("done_latency", lat, 9);
        issue(ld(1'b0));
        for (int i = 0; i < 9; i++)
            rd_exp(rdt(i), "ident_c", 8'(i + 1));

        for (int i = 0; i < 18; i++)
            set_t(i, 8'd20);
        run_mul(lat);
        chk("done_latency_ovf", lat, 9);
        issue(ld(1'b0));
        rd_exp(rdt(0), "ovf_c0", OVF);
        rd_exp(rdt(4), "ovf_c4", OVF);
        rd_exp(rdt(8), "ovf_c8", OVF);
        rd_exp(rdt(9), "ovf_b_kept", 8'd20);

        issue(addi(6, 8'd79));
        issue(c2t(20, 6));
        rd_exp(rdt(17), "bad_td_t17", 8'd20);
        rd_exp(rdt(9), "bad_td_t9", 8'd20);
        rd_exp(rdt(25), "bad_ts_read", 8'd0);
        issue(t2c(3, 25));
        rd_exp(rdc(3), "bad_ts_t2c", 8'd0);
        issue(mvt(1, 9));
        rd_exp(rdt(1), "move_tensor", 8'd20);

        rd_exp(rdc(6), "pre_reset_out", 8'd99);
        issue(OPR);
        repeat (4) issue(NOP);
        issue(RST);
        issue(NOP);
        chk("sync_rst_out", {24'b0, cpu_output}, 0);
        chk("sync_rst_done", {31'b0, done}, 0);
        repeat (12) issue(NOP);
        chk("sync_rst_done_late", {31'b0, done}, 0);
        rd_exp(rdc(1), "sync_rst_r1", 8'd0);
        for (int i = 0; i < 18; i++)
            rd_exp(rdt(i), "sync_rst_t", 8'd0);
        issue(ld(1'b1));
        rd_exp(rdt(9), "sync_rst_c", 8'd0);

        set_t(0, 8'd7);
        set_t(9, 8'd7);
        rd_exp(rdc(6), "pre_async_out", 8'd7);
        issue(OPR);
        repeat (4) issue(NOP);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {24'b0, cpu_output}, 0);
        chk("async_rst_done", {31'b0, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) issue(NOP);
        chk("async_rst_done_late", {31'b0, done}, 0);
        for (int i = 0; i < 18; i++)
            rd_exp(rdt(i), "async_rst_t", 8'd0);
        issue(ld(1'b0));
        rd_exp(rdt(0), "async_rst_c", 8'd0);

        repeat (3) issue(NOP);
        chk("scoreboard_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
